// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: default geometry, FSM
// state encoding and the read-pipe entry layout.
package data_sram_responder_pkg;

   localparam int unsigned DSRAM_ADDR_W = 12;
   localparam logic [31:0] DSRAM_BASE   = 32'h0000_0000;

   typedef enum logic {
      DSRAM_ST_INIT = 1'b0,
      DSRAM_ST_RUN  = 1'b1
   } dsram_state_t;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } dsram_rd_ent_t;

endpackage

// File: rtl/data_sram_responder_rd_pipe.sv
// Read-return pipe: LATENCY stages of {valid, err, data}. Each stage only
// captures err/data when a valid entry moves in, so the last stage keeps the
// most recent result, which lets rdata hold between reads.
module dsram_rd_pipe
   import data_sram_responder_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_err,
   input  logic [31:0] in_data,
   output logic        out_valid,
   output logic        out_err,
   output logic [31:0] out_data
);

   dsram_rd_ent_t stg_q [LATENCY];

   // Shift entries one stage per cycle; synchronous clear kills in-flight reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            stg_q[i] <= '0;
         end
      end else begin
         stg_q[0].valid <= in_valid;
         if (in_valid) begin
            stg_q[0].err  <= in_err;
            stg_q[0].data <= in_data;
         end
         for (int unsigned i = 1; i < LATENCY; i++) begin
            stg_q[i].valid <= stg_q[i-1].valid;
            if (stg_q[i-1].valid) begin
               stg_q[i].err  <= stg_q[i-1].err;
               stg_q[i].data <= stg_q[i-1].data;
            end
         end
      end
   end

   assign out_valid = stg_q[LATENCY-1].valid;
   assign out_err   = stg_q[LATENCY-1].valid & stg_q[LATENCY-1].err;
   assign out_data  = stg_q[LATENCY-1].data;

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-SRAM port: word-organised memory with byte
// enable writes, zero-fill after reset, and fixed-latency read return.
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int unsigned ADDR_W    = DSRAM_ADDR_W,
   parameter logic [31:0] BASE_ADDR = DSRAM_BASE,
   parameter int unsigned LATENCY   = 1,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        rdata_valid,
   output logic        addr_err,
   output logic        busy
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [31:0]       mem [DEPTH];
   dsram_state_t      state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q;
   logic [ADDR_W-1:0] idx;
   logic              in_rgn;
   logic              init_we, run_we, rd_req;
   logic [31:0]       rd_word;
   logic              unused_addr_lsbs;

   assign idx              = data_sram_addr[ADDR_W+1:2];
   assign in_rgn           = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign unused_addr_lsbs = &{1'b0, data_sram_addr[1:0]};

   // State register: reset enters INIT (or RUN when zero-fill is disabled).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT_ZERO ? DSRAM_ST_INIT : DSRAM_ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Fill counter: restarts at word 0 on every reset, advances only in INIT.
   always_ff @(posedge clk) begin
      if (reset || state_q != DSRAM_ST_INIT) begin
         init_cnt_q <= '0;
      end else begin
         init_cnt_q <= init_cnt_q + 1'b1;
      end
   end

   // Next state: leave INIT once the last word is being written.
   always_comb begin
      state_d = state_q;
      if (state_q == DSRAM_ST_INIT && init_cnt_q == '1) begin
         state_d = DSRAM_ST_RUN;
      end
   end

   // Outputs/strobes: requests are only honoured in RUN outside reset.
   always_comb begin
      busy    = reset | (state_q == DSRAM_ST_INIT);
      init_we = (state_q == DSRAM_ST_INIT) && !reset;
      run_we  = 1'b0;
      rd_req  = 1'b0;
      if (state_q == DSRAM_ST_RUN && !reset && data_sram_en) begin
         run_we = (data_sram_wen != 4'h0) && in_rgn;
         rd_req = (data_sram_wen == 4'h0);
      end
   end

   // Memory array: zero-fill during INIT, byte-lane writes in RUN.
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_cnt_q] <= '0;
      end else if (run_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
               mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   assign rd_word = in_rgn ? mem[idx] : '0;

   // Stage 1 of the pipe is the registered memory read.
   dsram_rd_pipe #(
      .LATENCY (LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_req),
      .in_err    (!in_rgn),
      .in_data   (rd_word),
      .out_valid (rdata_valid),
      .out_err   (addr_err),
      .out_data  (data_sram_rdata)
   );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder: three instances
// (latency 1, latency 3, zero-fill disabled) share one request stream.
module tb_data_sram_responder;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata1, rdata3, rdata_nz;
   logic        valid1, valid3, valid_nz;
   logic        err1, err3, err_nz;
   logic        busy1, busy3, busy_nz;

   int n_cmp = 0;
   int n_mis = 0;
   int n;
   logic saw_valid;

   data_sram_responder #(
      .ADDR_W    (4),
      .BASE_ADDR (32'h0000_0000),
      .LATENCY   (1),
      .INIT_ZERO (1'b1)
   ) u_l1 (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata1),
      .rdata_valid     (valid1),
      .addr_err        (err1),
      .busy            (busy1)
   );

   data_sram_responder #(
      .ADDR_W    (4),
      .BASE_ADDR (32'h0000_0000),
      .LATENCY   (3),
      .INIT_ZERO (1'b1)
   ) u_l3 (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata3),
      .rdata_valid     (valid3),
      .addr_err        (err3),
      .busy            (busy3)
   );

   data_sram_responder #(
      .ADDR_W    (4),
      .BASE_ADDR (32'h0000_0000),
      .LATENCY   (1),
      .INIT_ZERO (1'b0)
   ) u_nz (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata_nz),
      .rdata_valid     (valid_nz),
      .addr_err        (err_nz),
      .busy            (busy_nz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      en    = 1'b1;
      wen   = w;
      addr  = a;
      wdata = d;
      step();
      en    = 1'b0;
      wen   = 4'h0;
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      wen   = 4'h0;
      addr  = '0;
      wdata = '0;
      step();
      step();
      chk("rst_busy", {31'b0, busy1}, 32'd1);
      chk("rst_rdata", rdata1, 32'h0);
      chk("rst_valid", {31'b0, valid1}, 32'd0);
      chk("rst_err", {31'b0, err1}, 32'd0);
      chk("rst_busy_nz", {31'b0, busy_nz}, 32'd1);

      // Zero-fill of 16 words keeps busy high for 16 cycles.
      reset = 1'b0;
      n = 0;
      while (n < 100) begin
         step();
         n++;
         if (n == 1) chk("nz_skips_init", {31'b0, busy_nz}, 32'd0);
         if (!busy1) break;
      end
      chk("init_busy_cycles", n, 32'd16);
      chk("idle_valid", {31'b0, valid1}, 32'd0);

      // Read of a zero-filled word returns one cycle after the request.
      req(4'h0, 32'h3C, 32'h0);
      chk("rd3c_valid", {31'b0, valid1}, 32'd1);
      chk("rd3c_data", rdata1, 32'h0);
      chk("rd3c_err", {31'b0, err1}, 32'd0);
      step();
      chk("rd3c_pulse", {31'b0, valid1}, 32'd0);

      // Byte-enable merge.
      req(4'hF, 32'h8, 32'hDEADBEEF);
      chk("wr_no_valid", {31'b0, valid1}, 32'd0);
      req(4'b0010, 32'h8, 32'h0000_5500);
      req(4'h0, 32'h8, 32'h0);
      chk("be_merge", rdata1, 32'hDEAD55EF);
      chk("be_merge_valid", {31'b0, valid1}, 32'd1);

      // Write then read of the same word on the next cycle.
      req(4'hF, 32'h4, 32'h12345678);
      req(4'h0, 32'h4, 32'h0);
      chk("wr_rd_order", rdata1, 32'h12345678);
      step();
      step();
      chk("hold_data", rdata1, 32'h12345678);
      chk("hold_valid", {31'b0, valid1}, 32'd0);

      // Out-of-region read and dropped out-of-region write.
      req(4'h0, 32'h40, 32'h0);
      chk("oor_valid", {31'b0, valid1}, 32'd1);
      chk("oor_err", {31'b0, err1}, 32'd1);
      chk("oor_data", rdata1, 32'h0);
      req(4'hF, 32'h40, 32'hFFFFFFFF);
      req(4'h0, 32'h0, 32'h0);
      chk("oor_wr_word0", rdata1, 32'h0);
      chk("oor_wr_err", {31'b0, err1}, 32'd0);

      // Latency-3 back-to-back reads.
      req(4'hF, 32'h0, 32'd1);
      req(4'hF, 32'h4, 32'd2);
      req(4'hF, 32'h8, 32'd3);
      en = 1'b1; wen = 4'h0; addr = 32'h0;
      step();
      chk("l3_t1_valid", {31'b0, valid3}, 32'd0);
      addr = 32'h4;
      step();
      chk("l3_t2_valid", {31'b0, valid3}, 32'd0);
      addr = 32'h8;
      step();
      chk("l3_t3_valid", {31'b0, valid3}, 32'd1);
      chk("l3_t3_data", rdata3, 32'd1);
      en = 1'b0;
      step();
      chk("l3_t4_valid", {31'b0, valid3}, 32'd1);
      chk("l3_t4_data", rdata3, 32'd2);
      step();
      chk("l3_t5_valid", {31'b0, valid3}, 32'd1);
      chk("l3_t5_data", rdata3, 32'd3);
      step();
      chk("l3_t6_valid", {31'b0, valid3}, 32'd0);
      chk("l3_hold_data", rdata3, 32'd3);

      // Reset one cycle after a latency-3 read kills it.
      req(4'h0, 32'h8, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("kill_valid", {31'b0, valid3}, 32'd0);
      chk("kill_rdata", rdata3, 32'h0);

      // Reset midway through INIT restarts the fill; requests while busy drop.
      step();
      step();
      step();
      chk("mid_init_busy", {31'b0, busy1}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      n = 0;
      saw_valid = 1'b0;
      while (n < 100) begin
         if (n == 3) begin
            en = 1'b1; wen = 4'h0; addr = 32'h8;
         end else if (n == 4) begin
            en = 1'b1; wen = 4'hF; addr = 32'h8; wdata = 32'hAAAAAAAA;
         end else begin
            en = 1'b0; wen = 4'h0;
         end
         step();
         n++;
         if (valid1) saw_valid = 1'b1;
         if (!busy1) break;
      end
      en  = 1'b0;
      wen = 4'h0;
      chk("restart_busy_cycles", n, 32'd16);
      chk("busy_no_valid", {31'b0, saw_valid}, 32'd0);
      req(4'h0, 32'h8, 32'h0);
      chk("busy_no_write", rdata1, 32'h0);
      chk("post_init_valid", {31'b0, valid1}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
